// File: rtl/spi_wrapper_pkg.sv
// ============================================================================
// Module  : spi_wrapper_pkg
// Purpose : FSM state encodings and frame command codes for the SPI wrapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_wrapper_pkg;

  typedef logic [2:0] spi_state_t;
  typedef logic [1:0] spi_cmd_t;

  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] CHK_CMD   = 3'b001;
  localparam logic [2:0] WRITE     = 3'b010;
  localparam logic [2:0] READ_ADD  = 3'b011;
  localparam logic [2:0] READ_DATA = 3'b100;

  localparam logic [1:0] c_CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] c_CMD_WR_DATA = 2'b01;
  localparam logic [1:0] c_CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] c_CMD_RD_DATA = 2'b11;

  localparam int c_FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/spi_ram.sv
// ============================================================================
// Module  : spi_ram
// Purpose : Single-port byte RAM driven by SPI frame commands.
//           SPI_RAM_CLEAR_EN: reset also zeroes every RAM word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_ram
  import spi_wrapper_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o
);

  logic [7:0]           RAM [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [1:0]           w_cmd;
  logic                 w_mem_wr;

  // Payload bits beyond the address width are dropped by the cast.
  assign w_addr   = ADDR_SIZE'(rx_data_i[7:0]);
  assign w_cmd    = rx_data_i[9:8];
  assign w_mem_wr = rx_valid_i && (w_cmd == c_CMD_WR_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      if (rx_valid_i) begin
        case (w_cmd)
          c_CMD_WR_ADDR: wr_addr <= w_addr;
          c_CMD_RD_ADDR: rd_addr <= w_addr;
          c_CMD_RD_DATA: begin
            tx_data_q  <= RAM[rd_addr];
            tx_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_RAM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) RAM[i] <= '0;
    end else if (w_mem_wr) begin
      RAM[wr_addr] <= rx_data_i[7:0];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_mem_wr) RAM[wr_addr] <= rx_data_i[7:0];
  end
`endif

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module  : spi_slave
// Purpose : SPI slave FSM; deserialises 10-bit frames, serialises read bytes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave
  import spi_wrapper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MOSI,
  input  logic       SS_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic [9:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       MISO
);

  spi_state_t cs;
  spi_state_t cs_d;
  logic [3:0] bit_cnt_q;
  logic [8:0] shift_q;
  logic [9:0] rx_data_q;
  logic       rx_valid_q;
  logic       rd_addr_stored_q;
  logic [6:0] tx_shift_q;
  logic [2:0] tx_cnt_q;
  logic       miso_q;
  logic       w_data_state;
  logic       w_shifting;

  assign w_data_state = (cs == WRITE) || (cs == READ_ADD) || (cs == READ_DATA);
  // The counter saturates at the frame length so trailing bits are ignored.
  assign w_shifting   = w_data_state && (bit_cnt_q < 4'(c_FRAME_BITS));

  always_comb begin
    cs_d = cs;
    if (SS_n) begin
      cs_d = IDLE;
    end else begin
      case (cs)
        IDLE:      cs_d = CHK_CMD;
        CHK_CMD:   cs_d = MOSI ? (rd_addr_stored_q ? READ_DATA : READ_ADD) : WRITE;
        WRITE,
        READ_ADD,
        READ_DATA: cs_d = cs;
        default:   cs_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs               <= IDLE;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      rd_addr_stored_q <= 1'b0;
      tx_shift_q       <= '0;
      tx_cnt_q         <= '0;
      miso_q           <= 1'b0;
    end else begin
      cs         <= cs_d;
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        tx_shift_q <= '0;
        tx_cnt_q   <= '0;
        miso_q     <= 1'b0;
      end else begin
        if (w_shifting) begin
          if (bit_cnt_q == 4'(c_FRAME_BITS - 1)) begin
            rx_data_q  <= {shift_q, MOSI};
            rx_valid_q <= 1'b1;
            bit_cnt_q  <= 4'(c_FRAME_BITS);
            if (cs == READ_ADD)  rd_addr_stored_q <= 1'b1;
            if (cs == READ_DATA) rd_addr_stored_q <= 1'b0;
          end else begin
            shift_q   <= {shift_q[7:0], MOSI};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end

        // MSB goes out on the edge that samples tx_valid, the rest follow.
        if (tx_valid_i) begin
          miso_q     <= tx_data_i[7];
          tx_shift_q <= tx_data_i[6:0];
          tx_cnt_q   <= 3'd7;
        end else if (tx_cnt_q != 3'd0) begin
          miso_q     <= tx_shift_q[6];
          tx_shift_q <= {tx_shift_q[5:0], 1'b0};
          tx_cnt_q   <= tx_cnt_q - 3'd1;
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign MISO       = miso_q;

endmodule

`default_nettype wire

// File: rtl/spi_wrapper.sv
// ============================================================================
// Module  : spi_wrapper
// Purpose : SPI slave connected to a command-addressed byte RAM.
//           SPI_RAM_CLEAR_EN: reset also clears the RAM contents.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_wrapper
  import spi_wrapper_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  output logic MISO,
  input  logic SS_n
);

  logic [9:0] rx_data_bus;
  logic       rx_valid;
  logic [7:0] tx_data_bus;
  logic       tx_valid;

  spi_slave SPI_INSATNCE (
    .clk        (clk),
    .rst_n      (rst_n),
    .MOSI       (MOSI),
    .SS_n       (SS_n),
    .tx_data_i  (tx_data_bus),
    .tx_valid_i (tx_valid),
    .rx_data_o  (rx_data_bus),
    .rx_valid_o (rx_valid),
    .MISO       (MISO)
  );

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) RAM_INSTANCE (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data_i  (rx_data_bus),
    .rx_valid_i (rx_valid),
    .tx_data_o  (tx_data_bus),
    .tx_valid_o (tx_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_wrapper.sv
// ============================================================================
// Module  : tb_spi_wrapper
// Purpose : Directed self-checking bench for spi_wrapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_wrapper;

  logic clk = 1'b0;
  logic rst_n;
  logic MOSI;
  logic MISO;
  logic SS_n;

  int checks = 0;
  int errors = 0;

  spi_wrapper #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MOSI  (MOSI),
    .MISO  (MISO),
    .SS_n  (SS_n)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic cmd_bit);
    SS_n = 1'b0;
    tick();
    MOSI = cmd_bit;
    tick();
  endtask

  task automatic send_bits(input logic [9:0] val, input int nbits);
    for (int i = 9; i > 9 - nbits; i--) begin
      MOSI = val[i];
      tick();
    end
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
  endtask

  task automatic collect_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick();
      b[i] = MISO;
    end
  endtask

  task automatic test_reset();
    logic [2:0] cs_v;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b000) begin
      errors++; $display("FAIL reset_cs got %b want 000", dut.SPI_INSATNCE.cs);
    end
    checks++;
    if (MISO !== 1'b0 || dut.RAM_INSTANCE.wr_addr !== 8'h00 || dut.RAM_INSTANCE.rd_addr !== 8'h00) begin
      errors++; $display("FAIL reset_regs got miso=%b wr=%h rd=%h want 0 00 00",
                         MISO, dut.RAM_INSTANCE.wr_addr, dut.RAM_INSTANCE.rd_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    cs_v = dut.SPI_INSATNCE.cs;
    if (cs_v !== 3'b000) begin
      errors++; $display("FAIL idle_ss_high got %b want 000", cs_v);
    end
    SS_n = 1'b0;
    tick();
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b001) begin
      errors++; $display("FAIL ss_low_chk_cmd got %b want 001", dut.SPI_INSATNCE.cs);
    end
    end_frame();
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b000) begin
      errors++; $display("FAIL ss_high_idle got %b want 000", dut.SPI_INSATNCE.cs);
    end
  endtask

  task automatic test_write_addr();
    start_frame(1'b0);
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b010) begin
      errors++; $display("FAIL wr_addr_state got %b want 010", dut.SPI_INSATNCE.cs);
    end
    send_bits(10'b00_1010_1001, 10);
    tick();
    checks++;
    if (dut.RAM_INSTANCE.wr_addr !== 8'hA9) begin
      errors++; $display("FAIL wr_addr got %h want a9", dut.RAM_INSTANCE.wr_addr);
    end
    end_frame();
  endtask

  task automatic test_write_data();
    start_frame(1'b0);
    send_bits(10'b01_0100_1101, 10);
    tick();
    checks++;
    if (dut.RAM_INSTANCE.RAM[8'hA9] !== 8'h4D) begin
      errors++; $display("FAIL wr_data got %h want 4d", dut.RAM_INSTANCE.RAM[8'hA9]);
    end
    checks++;
    if (dut.RAM_INSTANCE.RAM[8'hAA] !== 8'h5A) begin
      errors++; $display("FAIL ram_neighbour got %h want 5a", dut.RAM_INSTANCE.RAM[8'hAA]);
    end
    end_frame();
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b000) begin
      errors++; $display("FAIL wr_data_idle got %b want 000", dut.SPI_INSATNCE.cs);
    end
  endtask

  task automatic test_read_addr(input logic [7:0] addr);
    start_frame(1'b1);
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b011) begin
      errors++; $display("FAIL rd_addr_state got %b want 011", dut.SPI_INSATNCE.cs);
    end
    send_bits({2'b10, addr}, 10);
    tick();
    checks++;
    if (dut.RAM_INSTANCE.rd_addr !== addr) begin
      errors++; $display("FAIL rd_addr got %h want %h", dut.RAM_INSTANCE.rd_addr, addr);
    end
    end_frame();
  endtask

  task automatic test_read_data(input logic [7:0] expected);
    logic [7:0] got;
    start_frame(1'b1);
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b100) begin
      errors++; $display("FAIL rd_data_state got %b want 100", dut.SPI_INSATNCE.cs);
    end
    send_bits(10'b11_0111_1001, 10);
    tick();
    checks++;
    if (MISO !== 1'b0) begin
      errors++; $display("FAIL miso_pre_idle got %b want 0", MISO);
    end
    collect_byte(got);
    checks++;
    if (got !== expected) begin
      errors++; $display("FAIL miso_byte got %h want %h", got, expected);
    end
    tick();
    checks++;
    if (MISO !== 1'b0 || dut.SPI_INSATNCE.cs !== 3'b100) begin
      errors++; $display("FAIL miso_post got miso=%b cs=%b want 0 100", MISO, dut.SPI_INSATNCE.cs);
    end
    end_frame();
    // The stored read address was consumed, so the next read starts over.
    start_frame(1'b1);
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b011) begin
      errors++; $display("FAIL flag_cleared got %b want 011", dut.SPI_INSATNCE.cs);
    end
    end_frame();
  endtask

  task automatic test_abort();
    start_frame(1'b0);
    send_bits(10'b01_1111_0000, 5);
    end_frame();
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b000 || dut.RAM_INSTANCE.RAM[8'hA9] !== 8'h4D) begin
      errors++; $display("FAIL abort_partial got cs=%b ram=%h want 000 4d",
                         dut.SPI_INSATNCE.cs, dut.RAM_INSTANCE.RAM[8'hA9]);
    end
    start_frame(1'b0);
    send_bits(10'b01_0011_1100, 10);
    tick();
    checks++;
    if (dut.RAM_INSTANCE.RAM[8'hA9] !== 8'h3C) begin
      errors++; $display("FAIL abort_full got %h want 3c", dut.RAM_INSTANCE.RAM[8'hA9]);
    end
    end_frame();
  endtask

  task automatic test_back_to_back();
    start_frame(1'b0);
    send_bits(10'b00_0001_0000, 10);
    end_frame();
    start_frame(1'b0);
    send_bits(10'b01_1000_0001, 10);
    end_frame();
    checks++;
    if (dut.RAM_INSTANCE.RAM[8'h10] !== 8'h81) begin
      errors++; $display("FAIL b2b_write got %h want 81", dut.RAM_INSTANCE.RAM[8'h10]);
    end
    test_read_addr(8'h10);
    test_read_data(8'h81);
    test_read_addr(8'hAA);
    test_read_data(8'h5A);
  endtask

  task automatic test_reset_mid();
    start_frame(1'b0);
    send_bits(10'b00_1111_1111, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut.SPI_INSATNCE.cs !== 3'b000 || dut.RAM_INSTANCE.wr_addr !== 8'h00) begin
      errors++; $display("FAIL async_reset got cs=%b wr=%h want 000 00",
                         dut.SPI_INSATNCE.cs, dut.RAM_INSTANCE.wr_addr);
    end
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(1'b0);
    send_bits(10'b00_0000_0111, 10);
    tick();
    checks++;
    if (dut.RAM_INSTANCE.wr_addr !== 8'h07) begin
      errors++; $display("FAIL post_reset_frame got %h want 07", dut.RAM_INSTANCE.wr_addr);
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    dut.RAM_INSTANCE.RAM[8'hAA] = 8'h5A;
    test_write_addr();
    test_write_data();
    test_read_addr(8'hA9);
    test_read_data(8'h4D);
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_wrapper.md
SPI_WRAPPER -- requirements
Module: spi_wrapper

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, number of RAM words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, RAM address width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports `clk` and `rst_n`.
REQ-004 Port `clk`: input, 1 bit, system clock (SPI sampling clock); all state updates on the rising edge.
REQ-005 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-006 Port `MOSI`: input, 1 bit, serial data in, MSB first.
REQ-007 Port `MISO`: output, 1 bit, serial data out, MSB first.
REQ-008 Port `SS_n`: input, 1 bit, active-low slave select.

Function
REQ-009 The SPI FSM states SHALL be IDLE=000, CHK_CMD=001, WRITE=010, READ_ADD=011, READ_DATA=100, held in register `cs`.
REQ-010 IDLE SHALL go to CHK_CMD on the first edge with SS_n=0.
REQ-011 In CHK_CMD, the FSM SHALL branch on MOSI at the next edge:
- MOSI=0 -> WRITE.
- MOSI=1 with no read address stored -> READ_ADD.
- MOSI=1 with a read address stored -> READ_DATA.
REQ-012 SS_n=1 in any state SHALL return the FSM to IDLE on the next edge, abort any transfer and clear the bit counter.
REQ-013 In WRITE, READ_ADD and READ_DATA, the FSM SHALL shift in 10 MOSI bits MSB first; MOSI is sampled on each edge, starting with the edge after the CHK_CMD branch.
REQ-014 On the edge capturing the 10th bit, rx_data[9:0] SHALL be loaded and rx_valid SHALL be 1 for exactly one cycle.
REQ-015 rx_data[9:8] SHALL be the command:
- 00: write address; wr_addr <= rx_data[7:0].
- 01: write data; RAM[wr_addr] <= rx_data[7:0].
- 10: read address; rd_addr <= rx_data[7:0].
- 11: read data; tx_data <= RAM[rd_addr].
REQ-016 The RAM SHALL act one edge after rx_valid (the edge where rx_valid is sampled high).
REQ-017 The read-address-stored flag SHALL be set when READ_ADD completes 10 bits and cleared when READ_DATA completes.
REQ-018 On command 11, the RAM SHALL assert tx_valid with tx_data on the same edge it loads tx_data.
REQ-019 On the next edge, MISO SHALL show tx_data[7], then tx_data[6..0] on the 7 following edges; the FSM stays in READ_DATA until SS_n=1.
REQ-020 MISO SHALL be 0 whenever no byte is being transmitted.
REQ-021 Address bits above ADDR_SIZE in rx_data[7:0] SHALL be ignored; accesses SHALL not wrap beyond MEM_DEPTH-1 by design.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear the following:
- cs to IDLE.
- Bit counter, rx_data and rx_valid to 0.
- Read-address-stored flag.
- wr_addr, rd_addr, tx_data and tx_valid to 0.
- MISO to 0.
REQ-023 Reset mid-transfer SHALL discard the partial frame.

Configuration
REQ-024 With SPI_RAM_CLEAR_EN defined, reset SHALL also zero all MEM_DEPTH RAM words.
REQ-025 Without SPI_RAM_CLEAR_EN, RAM contents SHALL be unaffected by reset and preloadable by the bench.

Structure
REQ-026 A shared package SHALL hold the state encodings and command codes 00, 01, 10, 11.
REQ-027 The SPI slave FSM SHALL be sub-module spi_slave, instance SPI_INSATNCE.
REQ-028 The RAM SHALL be sub-module spi_ram, instance RAM_INSTANCE, with array RAM and registers wr_addr and rd_addr.
REQ-029 The wrapper SHALL expose nets rx_data_bus[9:0], rx_valid, tx_data_bus[7:0] and tx_valid between the two instances.

Verification
REQ-030 Reset then SS_n=1 -> cs=IDLE; SS_n=0 -> cs=CHK_CMD after 1 edge.
REQ-031 Write address: CHK_CMD with MOSI=0, then bits 00_1010_1001 -> cs=WRITE, and wr_addr=0xA9 one edge after the 10th bit.
REQ-032 Write data: frame 01_0100_1101 -> RAM[0xA9]=0x4D; SS_n=1 -> cs=IDLE.
REQ-033 Read address: CHK_CMD with MOSI=1, then 10_1010_1001 -> cs=READ_ADD, and rd_addr=0xA9.
REQ-034 Read data: CHK_CMD with MOSI=1, then 11_0111_1001 -> cs=READ_DATA; 2 edges after the 10th bit, MISO over 8 cycles = 0x4D MSB first.
REQ-035 Abort: SS_n=1 after 5 bits, then a full write-data frame -> only the full frame is written.
